// File: rtl/mbm_antilog.sv
// mbm_antilog: antilogarithm back end of a Mitchell-style 8x8 multiplier.
// Two-stage valid/ready pipeline. S1 decodes the log-domain word into an
// exponent and mantissa. S2 shifts the mantissa into the linear-domain product.
// Optional feature macro: MBM_ANTILOG_ROUND_EN (round half up instead of truncate).
module mbm_antilog (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [3:0]  in_char,
  input  logic [6:0]  in_frac,
  input  logic        in_frac_cout,
  input  logic        in_zero,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] out_product
);

  // Stage 1 registers: decoded exponent, mantissa with hidden one, zero flag
  logic        r_s1Valid;
  logic [3:0]  r_s1Exp;
  logic [7:0]  r_s1Mant;
  logic        r_s1Zero;

  // Stage 2 registers: finished product waiting for the consumer
  logic        r_s2Valid;
  logic [15:0] r_product;

  logic        w_s2CanLoad;
  logic        w_s2Load;
  logic        w_inFire;
  logic [3:0]  w_exp;
  logic [15:0] w_shifted;
  logic [15:0] w_result;

  // S2 frees up when it is empty or its word leaves on this edge
  assign w_s2CanLoad = !r_s2Valid || out_ready;
  assign w_s2Load    = r_s1Valid && w_s2CanLoad;

  // S1 can take a word when empty or when its word moves on to S2
  assign in_ready = !r_s1Valid || w_s2CanLoad;
  assign w_inFire = in_valid && in_ready;

  // Exponent is the characteristic plus the fraction carry; legal inputs stay within 15
  assign w_exp = in_char + {3'b000, in_frac_cout};

  // Mantissa is 1.frac scaled by 2^7; shift left by e, then drop the 7 fraction bits
  assign w_shifted = 16'((23'(r_s1Mant) << r_s1Exp) >> 7);

`ifdef MBM_ANTILOG_ROUND_EN
  logic w_roundBit;

  // Only exponents below 7 discard bits; the highest discarded bit is m[6-e]
  assign w_roundBit = (r_s1Exp < 4'd7) && r_s1Mant[3'(4'd6 - r_s1Exp)];
  assign w_result   = r_s1Zero ? 16'h0000 : (w_shifted + {15'd0, w_roundBit});
`else
  assign w_result = r_s1Zero ? 16'h0000 : w_shifted;
`endif

  // Stage 1: capture a new word on input transfer, otherwise empty when it moves to S2
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1Valid <= 1'b0;
      r_s1Exp   <= 4'd0;
      r_s1Mant  <= 8'd0;
      r_s1Zero  <= 1'b0;
    end else if (w_inFire) begin
      r_s1Valid <= 1'b1;
      r_s1Exp   <= w_exp;
      r_s1Mant  <= {1'b1, in_frac};
      r_s1Zero  <= in_zero;
    end else if (w_s2Load) begin
      r_s1Valid <= 1'b0;
    end
  end

  // Stage 2: take the shifted result from S1, or drain when the consumer takes it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s2Valid <= 1'b0;
      r_product <= 16'h0000;
    end else if (w_s2Load) begin
      r_s2Valid <= 1'b1;
      r_product <= w_result;
    end else if (out_ready) begin
      r_s2Valid <= 1'b0;
    end
  end

  assign out_valid   = r_s2Valid;
  assign out_product = r_product;

endmodule

// File: tb/tb_mbm_antilog.sv
// tb_mbm_antilog: self-checking bench for mbm_antilog.
// Directed vectors, a backpressure stall, a mid-flight reset and a randomized
// stream, all checked against an arithmetic reference model via a queue.
module tb_mbm_antilog;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  in_char;
  logic [6:0]  in_frac;
  logic        in_frac_cout;
  logic        in_zero;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_product;

  int          checks = 0;
  int          errors = 0;
  logic [15:0] expQ[$];
  bit          prevStall = 1'b0;
  logic [15:0] prevProduct = 16'h0000;
  bit          streamDone = 1'b0;

  mbm_antilog dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_char     (in_char),
    .in_frac     (in_frac),
    .in_frac_cout(in_frac_cout),
    .in_zero     (in_zero),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_product (out_product)
  );

  always #5 clk = ~clk;

  // Reference: value = (1 + frac/128) * 2^e, truncated or rounded half up
  function automatic logic [15:0] model(input int c, input int f, input int co, input int z);
    longint scaled;
    longint q;
    longint rem;
    int     e;
    if (z != 0) return 16'h0000;
    e = c + co;
    scaled = longint'(128 + f);
    for (int k = 0; k < e; k++) scaled = scaled * 2;
    q   = scaled / 128;
    rem = scaled % 128;
`ifdef MBM_ANTILOG_ROUND_EN
    if (rem >= 64) q = q + 1;
`else
    if (rem < 0) q = 0;
`endif
    return q[15:0];
  endfunction

  task automatic checkOutput(input string tag, input logic [15:0] observed, input logic [15:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Align to just after a rising edge before presenting a word
  task automatic syncInput();
    @(posedge clk);
    #1;
  endtask

  // Present one word, wait (bounded) for acceptance, record its expected product
  task automatic applyStimulus(input logic [3:0] c, input logic [6:0] f, input logic co, input logic z);
    int waited;
    waited       = 0;
    in_valid     = 1'b1;
    in_char      = c;
    in_frac      = f;
    in_frac_cout = co;
    in_zero      = z;
    @(negedge clk);
    while (!in_ready && waited < 50) begin
      waited++;
      @(negedge clk);
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $error("[TB] FAIL accept_timeout observed=in_ready_low expected=in_ready_high");
      in_valid = 1'b0;
    end else begin
      expQ.push_back(model(int'(c), int'(f), int'(co), int'(z)));
      @(posedge clk);
      #1;
      in_valid = 1'b0;
    end
  endtask

  // Wait (bounded) until every accepted word has come out
  task automatic waitDrain();
    int n;
    n = 0;
    while (expQ.size() != 0 && n < 200) begin
      n++;
      @(negedge clk);
    end
    if (expQ.size() != 0) begin
      checks++;
      errors++;
      $error("[TB] FAIL drain_timeout observed=%0d pending expected=0 pending", expQ.size());
    end
  endtask

  // Output monitor: checks every transfer in order and holds during stalls
  initial begin
    logic [15:0] expVal;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (prevStall) begin
          checkOutput("hold_valid", {15'd0, out_valid}, 16'd1);
          checkOutput("hold_product", out_product, prevProduct);
        end
        if (out_valid && out_ready) begin
          if (expQ.size() == 0) begin
            checks++;
            errors++;
            $error("[TB] FAIL unexpected_output observed=%0h expected=none", out_product);
          end else begin
            expVal = expQ.pop_front();
            checkOutput("product", out_product, expVal);
          end
        end
        prevStall   = out_valid && !out_ready;
        prevProduct = out_product;
      end else begin
        prevStall = 1'b0;
      end
    end
  end

  initial begin
    rst_n        = 1'b0;
    in_valid     = 1'b0;
    in_char      = 4'd0;
    in_frac      = 7'd0;
    in_frac_cout = 1'b0;
    in_zero      = 1'b0;
    out_ready    = 1'b1;

    // Reset state
    #1;
    checkOutput("rst_out_valid", {15'd0, out_valid}, 16'd0);
    checkOutput("rst_out_product", out_product, 16'h0000);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    checkOutput("rst_in_ready", {15'd0, in_ready}, 16'd1);

    // Directed vectors, with a latency check on the first
    syncInput();
    applyStimulus(4'd5, 7'h00, 1'b0, 1'b0);
    @(negedge clk);
    checkOutput("latency_s1", {15'd0, out_valid}, 16'd0);
    @(negedge clk);
    checkOutput("latency_s2", {15'd0, out_valid}, 16'd1);
    syncInput();
    applyStimulus(4'd3,  7'h40, 1'b0, 1'b0);
    applyStimulus(4'd14, 7'h7F, 1'b1, 1'b0);
    applyStimulus(4'd0,  7'h60, 1'b0, 1'b0);
    applyStimulus(4'd9,  7'h55, 1'b0, 1'b1);
    applyStimulus(4'd15, 7'h00, 1'b0, 1'b0);
    waitDrain();

    // Backpressure: four back-to-back words with the consumer stalled
    syncInput();
    out_ready = 1'b0;
    applyStimulus(4'd2, 7'h11, 1'b0, 1'b0);
    applyStimulus(4'd7, 7'h22, 1'b1, 1'b0);
    checkOutput("stall_in_ready", {15'd0, in_ready}, 16'd0);
    fork
      begin
        applyStimulus(4'd10, 7'h33, 1'b0, 1'b0);
        applyStimulus(4'd1,  7'h7E, 1'b1, 1'b0);
      end
      begin
        @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    waitDrain();

    // Reset while both stages hold words
    syncInput();
    out_ready = 1'b0;
    applyStimulus(4'd4, 7'h05, 1'b0, 1'b0);
    applyStimulus(4'd6, 7'h06, 1'b0, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("async_rst_out_valid", {15'd0, out_valid}, 16'd0);
    checkOutput("async_rst_out_product", out_product, 16'h0000);
    expQ.delete();
    @(negedge clk);
    @(posedge clk);
    #2 rst_n = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    checkOutput("post_rst_in_ready", {15'd0, in_ready}, 16'd1);
    checkOutput("post_rst_out_valid", {15'd0, out_valid}, 16'd0);

    // Randomized stream with random consumer backpressure and input gaps
    syncInput();
    streamDone = 1'b0;
    fork
      begin
        for (int i = 0; i < 200; i++) begin
          if ($urandom_range(0, 3) == 0) syncInput();
          applyStimulus(4'($urandom_range(0, 14)), 7'($urandom), 1'($urandom),
                        ($urandom_range(0, 7) == 0));
        end
        streamDone = 1'b1;
      end
      begin
        while (!streamDone) begin
          @(posedge clk);
          #1 out_ready = 1'($urandom_range(0, 1));
        end
      end
    join
    out_ready = 1'b1;
    waitDrain();

    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
